driver: RTL and testbench

DRIVER -- requirements
Module: driver

---
 rtl/driver.sv | 54 +++++
 tb/tb_driver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver.sv
// Tri-state bus driver with registered activity/last-value tracking.
// Optional enabled-cycle counter (drive_cnt) compiled in with macro DRIVER_STATS_EN.
module driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_en,
  output logic [WIDTH-1:0] data_out,
  input  logic             cnt_clr,
`ifdef DRIVER_STATS_EN
  output logic [CNT_W-1:0] drive_cnt,
`endif
  output logic             drive_active,
  output logic [WIDTH-1:0] last_data
);

  // Valid/ready: none. data_en is a plain level; every rising edge samples
  // only the current inputs, and the bus driver below is purely combinational.

  // Reset does not gate the bus; an X/Z enable propagates as X/Z, never a stale value.
  assign data_out = data_en ? data_in : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_active <= 1'b0;
      last_data    <= '0;
    end else begin
      drive_active <= data_en;
      if (data_en) begin
        last_data <= data_in;
      end
    end
  end

`ifdef DRIVER_STATS_EN
  // Clear beats increment; the count saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_cnt <= '0;
    end else if (cnt_clr) begin
      drive_cnt <= '0;
    end else if (data_en && (drive_cnt != {CNT_W{1'b1}})) begin
      drive_cnt <= drive_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_driver.sv
// Self-checking bench for driver; build with +define+DRIVER_STATS_EN to cover drive_cnt.
module tb_driver;

  localparam int WIDTH = 8;
`ifdef DRIVER_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             data_en;
  logic             cnt_clr;
  wire  [WIDTH-1:0] data_out;
  logic             drive_active;
  logic [WIDTH-1:0] last_data;
`ifdef DRIVER_STATS_EN
  logic [CNT_W-1:0] drive_cnt;
  logic [CNT_W-1:0] cnt_q[$];
`endif

  logic [WIDTH-1:0] exp_q[$];
  logic             act_q[$];
  int               tests_run;
  int               tests_failed;

  driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_en      (data_en),
    .data_out     (data_out),
    .cnt_clr      (cnt_clr),
`ifdef DRIVER_STATS_EN
    .drive_cnt    (drive_cnt),
`endif
    .drive_active (drive_active),
    .last_data    (last_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then land 1 unit past the rising edge.
  task automatic drive_cycle(input logic en, input logic [WIDTH-1:0] din, input logic clr);
    @(negedge clk);
    data_en = en;
    data_in = din;
    cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [WIDTH-1:0] exp_v;
    rst_n   = 1'b0;
    data_en = 1'b0;
    data_in = '0;
    cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    act_q.push_back(1'b0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (last_data !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_last_data got=%h exp=%h", last_data, exp_v);
    end
    tests_run++;
    if (drive_active !== act_q.pop_front()) begin
      tests_failed++;
      $display("FAIL reset_drive_active got=%b exp=0", drive_active);
    end
`ifdef DRIVER_STATS_EN
    tests_run++;
    if (drive_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_drive_cnt got=%0d exp=0", drive_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_drive;
    logic [WIDTH-1:0] exp_v;
    @(negedge clk);
    data_en = 1'b1;
    data_in = 8'hA5;
    exp_q.push_back(8'hA5);
    #1;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (data_out !== exp_v) begin
      tests_failed++;
      $display("FAIL comb_en_a5 got=%h exp=%h", data_out, exp_v);
    end
    data_en = 1'b0;
    data_in = 8'h3C;
    exp_q.push_back({WIDTH{1'bz}});
    #1;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (data_out !== exp_v) begin
      tests_failed++;
      $display("FAIL comb_release got=%h exp=%h", data_out, exp_v);
    end
    data_en = 1'b1;
    exp_q.push_back(8'h3C);
    #1;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (data_out !== exp_v) begin
      tests_failed++;
      $display("FAIL comb_reenable got=%h exp=%h", data_out, exp_v);
    end
  endtask

  task automatic test_random_comb;
    logic [WIDTH-1:0] exp_v;
    for (int i = 0; i < 10; i++) begin
      data_en = 1'($urandom_range(0, 1));
      data_in = WIDTH'($urandom_range(1, 255));
      exp_q.push_back(data_en ? data_in : {WIDTH{1'bz}});
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (data_out !== exp_v) begin
        tests_failed++;
        $display("FAIL random_comb[%0d] en=%b got=%h exp=%h", i, data_en, data_out, exp_v);
      end
    end
  endtask

  task automatic test_last_data;
    logic [WIDTH-1:0] exp_v;
    drive_cycle(1'b1, 8'h5A, 1'b0);
    exp_q.push_back(8'h5A);
    act_q.push_back(1'b1);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (last_data !== exp_v || drive_active !== act_q.pop_front()) begin
      tests_failed++;
      $display("FAIL last_load got=%h/%b exp=%h/1", last_data, drive_active, exp_v);
    end
    drive_cycle(1'b0, 8'hFF, 1'b0);
    exp_q.push_back(8'h5A);
    act_q.push_back(1'b0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (last_data !== exp_v || drive_active !== act_q.pop_front()) begin
      tests_failed++;
      $display("FAIL last_hold got=%h/%b exp=%h/0", last_data, drive_active, exp_v);
    end
    // cnt_clr must never disturb the data path
    drive_cycle(1'b1, 8'h96, 1'b1);
    exp_q.push_back(8'h96);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (last_data !== exp_v || drive_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL last_with_clr got=%h/%b exp=%h/1", last_data, drive_active, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] vals [4];
    logic [WIDTH-1:0] exp_v;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, vals[i], 1'b0);
      exp_q.push_back(vals[i]);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (last_data !== exp_v || drive_active !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b[%0d] got=%h/%b exp=%h/1", i, last_data, drive_active, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] exp_v;
    drive_cycle(1'b1, 8'hE7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (last_data !== exp_v || drive_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got=%h/%b exp=%h/0", last_data, drive_active, exp_v);
    end
`ifdef DRIVER_STATS_EN
    tests_run++;
    if (drive_cnt !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_cnt got=%0d exp=0", drive_cnt);
    end
`endif
    data_en = 1'b1;
    data_in = 8'h77;
    exp_q.push_back(8'h77);
    #1;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (data_out !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_bus_follow got=%h exp=%h", data_out, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    data_en = 1'b0;
    drive_cycle(1'b1, 8'hC3, 1'b0);
    exp_q.push_back(8'hC3);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (last_data !== exp_v || drive_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_edge_after_reset got=%h/%b exp=%h/1", last_data, drive_active, exp_v);
    end
  endtask

`ifdef DRIVER_STATS_EN
  task automatic test_stats;
    logic [CNT_W-1:0] exp_c;
    drive_cycle(1'b0, 8'h00, 1'b1);
    cnt_q.push_back(2'd0);
    exp_c = cnt_q.pop_front();
    tests_run++;
    if (drive_cnt !== exp_c) begin
      tests_failed++;
      $display("FAIL cnt_clear got=%0d exp=%0d", drive_cnt, exp_c);
    end
    cnt_q.push_back(2'd1); cnt_q.push_back(2'd2); cnt_q.push_back(2'd3);
    cnt_q.push_back(2'd3); cnt_q.push_back(2'd3);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, WIDTH'(i), 1'b0);
      exp_c = cnt_q.pop_front();
      tests_run++;
      if (drive_cnt !== exp_c) begin
        tests_failed++;
        $display("FAIL cnt_sat[%0d] got=%0d exp=%0d", i, drive_cnt, exp_c);
      end
    end
    drive_cycle(1'b1, 8'h01, 1'b1);
    cnt_q.push_back(2'd0);
    exp_c = cnt_q.pop_front();
    tests_run++;
    if (drive_cnt !== exp_c) begin
      tests_failed++;
      $display("FAIL cnt_clr_wins got=%0d exp=%0d", drive_cnt, exp_c);
    end
    drive_cycle(1'b0, 8'h02, 1'b0);
    cnt_q.push_back(2'd0);
    exp_c = cnt_q.pop_front();
    tests_run++;
    if (drive_cnt !== exp_c) begin
      tests_failed++;
      $display("FAIL cnt_hold got=%0d exp=%0d", drive_cnt, exp_c);
    end
    drive_cycle(1'b1, 8'h03, 1'b0);
    cnt_q.push_back(2'd1);
    exp_c = cnt_q.pop_front();
    tests_run++;
    if (drive_cnt !== exp_c) begin
      tests_failed++;
      $display("FAIL cnt_restart got=%0d exp=%0d", drive_cnt, exp_c);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_comb_drive();
    test_random_comb();
    test_last_data();
    test_back_to_back();
    test_reset_mid();
`ifdef DRIVER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
